// File: rtl/uart_rx_engine.sv
// UART receive engine: configurable 5-8 data bits, parity, 1/2 stop bits, runtime divisor, FWFT FIFO.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_engine #(
  parameter int DIV_W      = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    data_len,
  input  logic                          parity_en,
  input  logic                          ohel,
  input  logic                          two_stop,
  input  logic                          rx,
  input  logic                          rd,
  output logic [7:0]                    rdata,
  output logic                          rdata_perr,
  output logic                          rdata_ferr,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic                          busy,
  output logic                          done,
  output logic                          brk
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_RX_BREAK_DET_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAITHI} state_t;
  state_t state_q, state_d;

  logic             rx_meta, rxs;
  logic [DIV_W-1:0] div_eff, div_q, cnt_q;
  logic [1:0]       len_q;
  logic             par_en_q, odd_q, two_stop_q;
  logic [7:0]       shreg_q;
  logic [2:0]       bit_q, last_bit;
  logic             stop_q, perr_q, ferr_q, par_bit_q;
  logic             btu, in_frame, zero_frame;
  logic             start_frame, shift_en, par_smp, stop1_en;
  logic [9:0]       entry;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign div_eff    = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;
  assign btu        = (cnt_q == '0);
  assign in_frame   = (state_q == START) || (state_q == DATA) ||
                      (state_q == PARITY) || (state_q == STOP);
  assign busy       = in_frame;
  assign last_bit   = {1'b0, len_q} + 3'd4;
  // A break is all-zero data, parity and first stop bit, seen at the first stop sample.
  assign zero_frame = (shreg_q == 8'h00) && !par_bit_q && !stop_q && !rxs;
  assign entry      = {ferr_q | ~rxs, perr_q, shreg_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first so no latches are inferred.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    par_smp     = 1'b0;
    stop1_en    = 1'b0;
    done        = 1'b0;
    brk         = 1'b0;
    case (state_q)
      IDLE:   if (!rxs) begin
                state_d     = START;
                start_frame = 1'b1;
              end
      START:  if (btu) state_d = rxs ? IDLE : DATA;
      DATA:   if (btu) begin
                shift_en = 1'b1;
                if (bit_q == last_bit) state_d = par_en_q ? PARITY : STOP;
              end
      PARITY: if (btu) begin
                par_smp = 1'b1;
                state_d = STOP;
              end
      STOP:   if (btu) begin
                if (BRK_EN && zero_frame) begin
                  brk     = 1'b1;
                  state_d = WAITHI;
                end else if (two_stop_q && !stop_q) begin
                  stop1_en = 1'b1;
                end else begin
                  done    = 1'b1;
                  state_d = rxs ? IDLE : WAITHI;
                end
              end
      WAITHI: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      odd_q      <= 1'b0;
      two_stop_q <= 1'b0;
      shreg_q    <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      par_bit_q  <= 1'b0;
    end else begin
      if (start_frame) begin
        div_q      <= div_eff;
        cnt_q      <= div_eff >> 1;
        len_q      <= data_len;
        par_en_q   <= parity_en;
        odd_q      <= ohel;
        two_stop_q <= two_stop;
        shreg_q    <= '0;
        bit_q      <= '0;
        stop_q     <= 1'b0;
        perr_q     <= 1'b0;
        ferr_q     <= 1'b0;
        par_bit_q  <= 1'b0;
      end else if (in_frame) begin
        cnt_q <= btu ? div_q - DIV_W'(1) : cnt_q - DIV_W'(1);
      end
      if (shift_en) begin
        shreg_q[bit_q] <= rxs;
        bit_q          <= bit_q + 3'd1;
      end
      if (par_smp) begin
        par_bit_q <= rxs;
        perr_q    <= rxs != ((^shreg_q) ^ odd_q);
      end
      if (stop1_en) begin
        stop_q <= 1'b1;
        ferr_q <= ~rxs;
      end
    end
  end

  // Receive FIFO, first-word-fall-through
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [9:0]    head;
  logic          full, pop, wr_en;

  assign rx_valid = (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = rd && rx_valid;
  assign wr_en    = done && (!full || pop);
  assign head     = mem[rd_ptr];
  assign rdata      = rx_valid ? head[7:0] : 8'h00;
  assign rdata_perr = rx_valid & head[8];
  assign rdata_ferr = rx_valid & head[9];

  // NOTE: storage is not reset; reads are masked by rx_valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (done && full && !pop) ovf <= 1'b1;
      else if (ovf_clr)         ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed self-checking bench for uart_rx_engine (default 20-bit divisor, 8-entry FIFO).
// Break-frame expectations follow UART_RX_BREAK_DET_EN as the RTL does.
module tb_uart_rx_engine;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] baud_div = 20'd16;
  logic [1:0]  data_len = 2'd3;
  logic        parity_en = 1'b0, ohel = 1'b0, two_stop = 1'b0;
  logic        rx = 1'b1, rd = 1'b0, ovf_clr = 1'b0;
  logic [7:0]  rdata;
  logic        rdata_perr, rdata_ferr, rx_valid, ovf, busy, done, brk;
  logic [3:0]  count;

  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, brk_cnt = 0;

  uart_rx_engine dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .data_len(data_len),
    .parity_en(parity_en), .ohel(ohel), .two_stop(two_stop), .rx(rx), .rd(rd),
    .rdata(rdata), .rdata_perr(rdata_perr), .rdata_ferr(rdata_ferr),
    .rx_valid(rx_valid), .count(count), .ovf(ovf), .ovf_clr(ovf_clr),
    .busy(busy), .done(done), .brk(brk)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (brk)  brk_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bitc(input logic v);
    rx = v;
    cyc(B);
  endtask

  task automatic cfg(input logic [1:0] len, input logic pe, input logic odd, input logic ts);
    data_len = len; parity_en = pe; ohel = odd; two_stop = ts;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pe,
                            input logic pbit, input int nstop, input logic [1:0] stops);
    bitc(1'b0);
    for (int i = 0; i < nbits; i++) bitc(d[i]);
    if (pe) bitc(pbit);
    for (int i = 0; i < nstop; i++) bitc(stops[i]);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    cyc(n * B);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, "_valid"}, rx_valid, 1'b1);
    check({tag, "_data"},  rdata, d);
    check({tag, "_perr"},  rdata_perr, pe);
    check({tag, "_ferr"},  rdata_ferr, fe);
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask

  // Latency from the first busy cycle to the done cycle; -1 when a bound expires.
  task automatic measure(output int lat);
    lat = -1;
    for (int i = 0; i < 2000 && !busy; i++) @(negedge clk);
    if (!busy) return;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        lat = i;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, d0, b0;
    bit seen;

    #2 rst = 1'b0;
    cyc(3);
    check("rst_count", count, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_brk",   brk, 0);
    check("rst_ovf",   ovf, 0);
    rst = 1'b1;
    cyc(4);

    // 7-bit frame, latency 8 + 16*8
    cfg(2'd2, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h2E, 7, 1'b0, 1'b0, 1, 2'b01);
      measure(lat);
    join
    check("b7_latency", lat, 136);
    idle_bits(2);
    check("b7_count", count, 1);
    pop_check("b7", 8'h2E, 1'b0, 1'b0);
    check("b7_count_after_rd", count, 0);
    check("b7_valid_after_rd", rx_valid, 0);

    // Odd parity on 0xAE (five ones): correct parity bit is 0
    cfg(2'd3, 1'b1, 1'b1, 1'b0);
    send_frame(8'hAE, 8, 1'b1, 1'b0, 1, 2'b01);
    idle_bits(2);
    send_frame(8'hAE, 8, 1'b1, 1'b1, 1, 2'b01);
    idle_bits(2);
    check("par_count", count, 2);
    pop_check("par_ok",  8'hAE, 1'b0, 1'b0);
    pop_check("par_bad", 8'hAE, 1'b1, 1'b0);

    // Five-cycle glitch must be rejected at the start check
    d0 = done_cnt;
    rx = 1'b0;
    cyc(5);
    rx = 1'b1;
    cyc(40);
    check("glitch_busy",  busy, 0);
    check("glitch_count", count, 0);
    check("glitch_done",  done_cnt - d0, 0);

    // Overflow: nine frames into an eight-entry FIFO
    cfg(2'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 8, 1'b0, 1'b0, 1, 2'b01);
      idle_bits(2);
    end
    check("ovf_count", count, 8);
    check("ovf_set",   ovf, 1);
    check("ovf_head",  rdata, 8'h01);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 0);

    // Push coinciding with rd while full: no overflow
    seen = 1'b0;
    fork
      send_frame(8'h0A, 8, 1'b0, 1'b0, 1, 2'b01);
      begin
        for (int i = 0; i < 1000 && !done; i++) @(negedge clk);
        if (done) begin
          seen = 1'b1;
          rd = 1'b1;
          cyc(1);
          rd = 1'b0;
        end
      end
    join
    idle_bits(2);
    check("coinc_done_seen", seen, 1);
    check("coinc_ovf",   ovf, 0);
    check("coinc_count", count, 8);
    for (int i = 2; i <= 8; i++) pop_check("ovf_rd", 8'(i), 1'b0, 1'b0);
    pop_check("ovf_rd_last", 8'h0A, 1'b0, 1'b0);
    check("ovf_drained", count, 0);

    // Two stop bits, second one low, line then held low
    cfg(2'd3, 1'b0, 1'b0, 1'b1);
    d0 = done_cnt;
    send_frame(8'h55, 8, 1'b0, 1'b0, 2, 2'b01);
    cyc(3 * B);
    check("fe_waithi_busy", busy, 0);
    check("fe_done_once",   done_cnt - d0, 1);
    idle_bits(2);
    check("fe_count", count, 1);
    pop_check("fe", 8'h55, 1'b0, 1'b1);

    // All-zero frame
    cfg(2'd3, 1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    b0 = brk_cnt;
    send_frame(8'h00, 8, 1'b0, 1'b0, 1, 2'b00);
    cyc(2 * B);
    idle_bits(2);
`ifdef UART_RX_BREAK_DET_EN
    check("brk_pulse", brk_cnt - b0, 1);
    check("brk_count", count, 0);
    check("brk_done",  done_cnt - d0, 0);
`else
    check("brk_none",  brk_cnt - b0, 0);
    check("brk_count", count, 1);
    pop_check("brk_entry", 8'h00, 1'b0, 1'b1);
`endif

    // Reset in the middle of a data field
    send_frame(8'h33, 8, 1'b0, 1'b0, 1, 2'b01);
    idle_bits(2);
    check("mid_pre_count", count, 1);
    bitc(1'b0);
    bitc(1'b1);
    bitc(1'b0);
    bitc(1'b1);
    check("mid_pre_busy", busy, 1);
    rst = 1'b0;
    rx = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_done",  done, 0);
    cyc(4);
    rst = 1'b1;
    idle_bits(1);
    send_frame(8'h41, 8, 1'b0, 1'b0, 1, 2'b01);
    idle_bits(2);
    check("mid_after_count", count, 1);
    pop_check("mid_after", 8'h41, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Parametrised UART receive engine with a configurable frame format, start-bit validation and a first-word-fall-through receive FIFO. Each byte is stored with its parity and framing error flags. It sits between the synchronised `rx` pin and the host/LED logic of the UART top level. It generalises the fixed 7/8-bit receiver with selectable data length (5–8), odd/even parity, 1 or 2 stop bits, a runtime baud divisor and buffering.

## Interface
- `DIV_W`, 20: width of the baud divisor.
- `FIFO_DEPTH`, 8: number of FIFO entries; must be a power of two, ≥2.
- `clk  in  1`: the single clock.
- `rst  in  1`: asynchronous, active-low reset.
- `baud_div  in  DIV_W`: clocks per bit; values below 4 are treated as 4.
- `data_len  in  2`: data bits = `data_len`+5.
- `parity_en  in  1`: a parity bit follows the data.
- `ohel  in  1`: parity sense; 1 = odd, 0 = even.
- `two_stop  in  1`: two stop bits.
- `rx  in  1`: serial input, asynchronous.
- `rd  in  1`: pop the FIFO head.
- `rdata  out  8`: head data, right-justified, unused upper bits 0.
- `rdata_perr  out  1`, `rdata_ferr  out  1`: error flags of the head entry.
- `rx_valid  out  1`: FIFO not empty.
- `count  out  clog2(FIFO_DEPTH)+1`: FIFO occupancy.
- `ovf  out  1`: sticky overflow flag.
- `ovf_clr  in  1`: clears `ovf`.
- `busy  out  1`: a frame is in progress.
- `done  out  1`: one-cycle pulse at the end of a frame.
- `brk  out  1`: one-cycle break pulse.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised `rxs`.
- The state machine has the states IDLE, START, DATA, PARITY, STOP, WAITHI.
- **IDLE:** `rxs`=0 moves to START.
  - `baud_div`, `data_len`, `parity_en`, `ohel` and `two_stop` are latched at this point; changes mid-frame are ignored.
  - The bit counter loads `baud_div`>>1.
- **Bit timer:** counts down; `btu` is asserted when the counter is 0. On `btu` the counter reloads `baud_div`−1.
- **START:** on `btu`, if `rxs`=0 go to DATA; if `rxs`=1 (false start) return to IDLE with nothing pushed.
- **DATA:** sample on each `btu`, LSB first, into the shift register.
  - After `data_len`+5 samples, go to PARITY if `parity_en`, else to STOP.
- **PARITY:** `perr` = sampled bit ≠ expected parity.
  - Expected parity: XOR of the data bits, inverted when `ohel`=1.
- **STOP:** sample 1 or 2 stop bits; `ferr` = any stop sample equals 0.
  - The final stop sample asserts `done` and pushes {`ferr`,`perr`,data}.
  - Next state: IDLE if `rxs`=1, otherwise WAITHI.
- **WAITHI:** return to IDLE when `rxs`=1. This prevents a low line from retriggering a frame.
- **FIFO behaviour:**
  - Push when full: the entry is dropped and `ovf` is set.
  - Push and `rd` in the same cycle when full: both happen, with no overflow.
  - `rd` when empty is ignored.
  - `ovf_clr` and an overflow in the same cycle: `ovf` stays 1.
- **Reset:** all outputs go to 0 and the FSM to IDLE. The FIFO is emptied and the pointers cleared. A reset mid-frame aborts the frame with nothing pushed.

## Timing
- `rx` to `rxs` latency is 2 cycles.
- From the first `rxs`=0 cycle:
  - The start is checked `baud_div`>>1 cycles later.
  - Each following sample is `baud_div` cycles after the previous one.
- The final stop sample, and therefore `done`, occurs (`baud_div`>>1) + `baud_div`·N cycles after the edge. N = data bits + parity bit + stop bits.
- `busy` is 1 from the cycle after the start edge through the `done` cycle.
- The push is registered on the `done` edge. `rx_valid`, `count` and `rdata` update the following cycle.
- `rdata` is first-word-fall-through: the head entry is always visible; `rd` advances it on the next edge.
- `ovf` sets on the edge of the dropped push.

## Configuration
- **`UART_RX_BREAK_DET_EN` defined:** a frame whose data bits, parity bit (if enabled) and first stop bit are all 0 is a break.
  - Nothing is pushed and `done` is not asserted.
  - `brk` pulses for one cycle at the stop sample, and the FSM goes to WAITHI.
- **Undefined:** `brk` is tied to 0, and a break frame is pushed as data 0x00 with `ferr`=1.

## Test plan
- **7-bit frame:** `baud_div`=16, `data_len`=2, no parity, 1 stop, send 0x2E.
  - `done` occurs 8+16·8=136 cycles after the `rxs` edge.
  - `rdata`=0x2E, `perr`=`ferr`=0, `count`=1.
  - `rd` then gives `count`=0 and `rx_valid`=0.
- **Parity:** `data_len`=3, `parity_en`=1, `ohel`=1, send 0xAE.
  - Parity bit 0 gives `perr`=0.
  - Parity bit 1 gives an entry 0xAE with `perr`=1.
- **Glitch rejection:** `rx` low for 5 cycles, `baud_div`=16.
  - START aborts, `busy` returns to 0, `count` stays 0, no `done`.
- **Overflow:** `FIFO_DEPTH`=8, 9 frames (0x01…0x09) with no `rd`.
  - `count`=8 and `ovf`=1; reads return 0x01…0x08.
  - `ovf_clr` clears `ovf`.
  - A push coinciding with `rd` while full leaves `ovf`=0.
- **Framing / break:**
  - `two_stop`=1, 0x55 with the second stop bit 0: `ferr`=1 and the FSM goes to WAITHI until `rx`=1.
  - All-zero frame with the macro defined: `brk` pulses and `count` is unchanged.
  - All-zero frame without the macro: entry 0x00 with `ferr`=1.
- **Reset mid-frame:** assert `rst`=0 during DATA.
  - All outputs go to 0 immediately.
  - After release, a following 0x41 frame is received correctly.
